// File: rtl/pcie_rx_mrd_bfm.sv
// Receive-side MRd capture for the RC-bypass bench: decodes incoming TLPs, queues MRd headers
// and their lookup IDs in show-ahead FIFOs for the completion generator, and counts dropped TLPs.
module pcie_rx_mrd_bfm #(
    parameter int HDR_WD = 128,
    parameter int DEPTH  = 16,
    parameter int CNT_WD = 16
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              rx_hv_i,
    input  logic [HDR_WD-1:0] rx_header_i,
    input  logic              rx_dv_i,
    input  logic              rx_eot_i,
    input  logic [9:0]        rx_lookup_id_i,
    output logic              rx_halt_o,
    input  logic              mrd_rden_i,
    output logic [HDR_WD-1:0] mrd_q_o,
    output logic              mrd_rdempty_o,
    input  logic              trgtlookup_id_rden_i,
    output logic [9:0]        trgtlookup_id_o,
    output logic [CNT_WD-1:0] mrd_cnt_o,
    output logic [CNT_WD-1:0] drop_cnt_o,
    output logic              err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0]     PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]     CNT_FULL = CW'(DEPTH);
    localparam logic [CNT_WD-1:0] STAT_ONE = {{(CNT_WD-1){1'b0}}, 1'b1};

    // DRAIN swallows trailing beats of an MRd that was already queued; DROP discards a whole TLP.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DROP  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [HDR_WD-1:0] hdr_mem_r [DEPTH];
    logic [9:0]        id_mem_r  [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     hdr_rd_ptr_r;
    logic [AW-1:0]     id_rd_ptr_r;
    logic [CW-1:0]     hdr_cnt_r;
    logic [CW-1:0]     id_cnt_r;
    logic [CNT_WD-1:0] mrd_cnt_r;
    logic [CNT_WD-1:0] drop_cnt_r;
    logic              err_r;

    logic              hdr_empty_s;
    logic              id_empty_s;
    logic              hdr_full_s;
    logic              id_full_s;
    logic              halt_s;
    logic              is_mrd_s;
    logic              accept_s;
    logic              push_s;
    logic              hdr_pop_s;
    logic              id_pop_s;
    logic              drop_inc_s;
    logic              err_set_s;
    logic              unused_s;

    function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] v);
        return (&v) ? v : (v + STAT_ONE);
    endfunction

    // Payload beats carry nothing this model needs; they are simply absorbed.
    assign unused_s = rx_dv_i;

    assign hdr_empty_s = (hdr_cnt_r == {CW{1'b0}});
    assign id_empty_s  = (id_cnt_r == {CW{1'b0}});
    assign hdr_full_s  = (hdr_cnt_r == CNT_FULL);
    assign id_full_s   = (id_cnt_r == CNT_FULL);
    assign halt_s      = hdr_full_s | id_full_s;

    // MRd is type 0 with a 3DW or 4DW no-data format; MRdLk (type 1) falls through to drop.
    assign is_mrd_s  = (rx_header_i[28:24] == 5'b00000) && (rx_header_i[31:30] == 2'b00);
    assign accept_s  = rx_hv_i & ~halt_s & (state_r == ST_IDLE);
    assign push_s    = accept_s & is_mrd_s;
    assign hdr_pop_s = mrd_rden_i & ~hdr_empty_s;
    assign id_pop_s  = trgtlookup_id_rden_i & ~id_empty_s;
    assign err_set_s = (mrd_rden_i & hdr_empty_s) | (trgtlookup_id_rden_i & id_empty_s) |
                       (push_s & halt_s);

    // Next-state and drop-count decision for the receive FSM.
    always_comb begin
        state_nxt_s = state_r;
        drop_inc_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (rx_eot_i) begin
                        drop_inc_s  = ~is_mrd_s;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        drop_inc_s  = 1'b0;
                        state_nxt_s = is_mrd_s ? ST_DRAIN : ST_DROP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (rx_eot_i && !halt_s) begin
                    drop_inc_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            ST_DRAIN: begin
                if (rx_eot_i && !halt_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FIFO storage; contents are not reset, the empty gating on the outputs hides stale data.
    always_ff @(posedge core_clk) begin
        if (push_s) begin
            hdr_mem_r[wr_ptr_r] <= rx_header_i;
            id_mem_r[wr_ptr_r]  <= rx_lookup_id_i;
        end
    end

    // Shared write pointer, independent read pointers and occupancy counts.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            wr_ptr_r     <= {AW{1'b0}};
            hdr_rd_ptr_r <= {AW{1'b0}};
            id_rd_ptr_r  <= {AW{1'b0}};
            hdr_cnt_r    <= {CW{1'b0}};
            id_cnt_r     <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (hdr_pop_s) begin
                hdr_rd_ptr_r <= hdr_rd_ptr_r + PTR_ONE;
            end
            if (id_pop_s) begin
                id_rd_ptr_r <= id_rd_ptr_r + PTR_ONE;
            end
            case ({push_s, hdr_pop_s})
                2'b10:   hdr_cnt_r <= hdr_cnt_r + CNT_ONE;
                2'b01:   hdr_cnt_r <= hdr_cnt_r - CNT_ONE;
                default: hdr_cnt_r <= hdr_cnt_r;
            endcase
            case ({push_s, id_pop_s})
                2'b10:   id_cnt_r <= id_cnt_r + CNT_ONE;
                2'b01:   id_cnt_r <= id_cnt_r - CNT_ONE;
                default: id_cnt_r <= id_cnt_r;
            endcase
        end
    end

    // Saturating statistics and the sticky error flag.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            mrd_cnt_r  <= {CNT_WD{1'b0}};
            drop_cnt_r <= {CNT_WD{1'b0}};
            err_r      <= 1'b0;
        end else begin
            if (push_s) begin
                mrd_cnt_r <= sat_inc(mrd_cnt_r);
            end
            if (drop_inc_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign rx_halt_o       = halt_s;
    assign mrd_rdempty_o   = hdr_empty_s;
    assign mrd_q_o         = hdr_empty_s ? {HDR_WD{1'b0}} : hdr_mem_r[hdr_rd_ptr_r];
    assign trgtlookup_id_o = id_empty_s ? 10'h000 : id_mem_r[id_rd_ptr_r];
    assign mrd_cnt_o       = mrd_cnt_r;
    assign drop_cnt_o      = drop_cnt_r;
    assign err_o           = err_r;

endmodule
